// File: rtl/regfile_wb_buffer.sv
// regfile_wb_buffer: merges load-unit and ALU register writes into a small
// circular FIFO that drains into a single register-file write port.
// Each drain cycle issues one write, and the drain can be stalled.
// Destination x0 requests are handshaken but dropped.
// The busy scoreboard reports which registers have writes still buffered.
// The fwd1/fwd2 bypass logic is built only when REGFILE_WB_FORWARD_EN is
// defined; otherwise the fwd outputs are tied to 0.
module regfile_wb_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  // load-unit request
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [63:0] ld_data,
  output logic        ld_ready,
  // ALU request
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [63:0] alu_data,
  output logic        alu_ready,
  // register-file write port
  input  logic        wb_stall,
  output logic        RegWrite,
  output logic [4:0]  rd,
  output logic [63:0] WriteData,
  // hazard / forwarding
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        fwd1_hit,
  output logic        fwd2_hit,
  output logic [63:0] fwd1_data,
  output logic [63:0] fwd2_data,
  output logic [31:0] busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

  // pointers and occupancy
  logic [AW-1:0]  r_rptr;
  logic [AW-1:0]  r_wptr;
  logic [AW:0]    r_count;

  // entry storage (not reset; validity comes from pointers/count)
  logic [4:0]     r_mem_rd   [DEPTH];
  logic [63:0]    r_mem_data [DEPTH];

  logic           w_deq;
  logic [AW+1:0]  w_free;
  logic           w_ld_need;
  logic           w_ld_enq;
  logic           w_alu_enq;
  logic [AW-1:0]  w_alu_idx;
  logic [AW:0]    w_enq_cnt;
  logic [DEPTH-1:0] w_entry_valid;

  // head leaves the buffer whenever something is queued and the port is free
  assign w_deq = (r_count != '0) & ~wb_stall;

  // a slot freed by this cycle's dequeue can be refilled in the same cycle
  assign w_free = DEPTH_W - {1'b0, r_count} + {{(AW+1){1'b0}}, w_deq};

  // an x0 load never occupies a slot, so it must not block the ALU
  assign w_ld_need = ld_valid & (ld_rd != 5'd0);

  assign ld_ready  = reset & (w_free >= (AW+2)'(1));
  assign alu_ready = reset & (w_free >= ((AW+2)'(1) + {{(AW+1){1'b0}}, w_ld_need}));

  assign w_ld_enq  = ld_valid  & ld_ready  & (ld_rd  != 5'd0);
  assign w_alu_enq = alu_valid & alu_ready & (alu_rd != 5'd0);

  // the load is older, so the ALU entry lands one slot behind it
  assign w_alu_idx = r_wptr + AW'(w_ld_enq);
  assign w_enq_cnt = (AW+1)'(w_ld_enq) + (AW+1)'(w_alu_enq);

  // pointer and count update; reset empties the buffer immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      r_rptr  <= r_rptr + AW'(w_deq);
      r_wptr  <= r_wptr + AW'(w_enq_cnt);
      r_count <= r_count + w_enq_cnt - (AW+1)'(w_deq);
    end
  end

  // entry writes: load first, ALU second
  always_ff @(posedge clk) begin
    if (w_ld_enq) begin
      r_mem_rd[r_wptr]   <= ld_rd;
      r_mem_data[r_wptr] <= ld_data;
    end
    if (w_alu_enq) begin
      r_mem_rd[w_alu_idx]   <= alu_rd;
      r_mem_data[w_alu_idx] <= alu_data;
    end
  end

  // write port is driven straight from the head entry
  assign RegWrite  = w_deq;
  assign rd        = (r_count != '0) ? r_mem_rd[r_rptr]   : 5'd0;
  assign WriteData = (r_count != '0) ? r_mem_data[r_rptr] : 64'd0;

  // a slot is live when its distance from the read pointer is below count
  genvar gi, ge;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_valid
      logic [AW-1:0] w_off;
      assign w_off             = AW'(gi) - r_rptr;
      assign w_entry_valid[gi] = ({1'b0, w_off} < r_count);
    end
  endgenerate

  // busy scoreboard: one OR-reduction per architectural register
  assign busy[0] = 1'b0;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_busy
      logic [DEPTH-1:0] w_match;
      for (ge = 0; ge < DEPTH; ge++) begin : g_ent
        assign w_match[ge] = w_entry_valid[ge] & (r_mem_rd[ge] == 5'(gi));
      end
      assign busy[gi] = |w_match;
    end
  endgenerate

`ifdef REGFILE_WB_FORWARD_EN
  logic [AW-1:0] w_fwd_idx;

  // scan oldest to youngest so the youngest matching entry wins
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd2_hit  = 1'b0;
    fwd1_data = 64'd0;
    fwd2_data = 64'd0;
    w_fwd_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_fwd_idx = r_rptr + AW'(k);
      if ((AW+1)'(k) < r_count) begin
        if ((rs1 != 5'd0) && (r_mem_rd[w_fwd_idx] == rs1)) begin
          fwd1_hit  = 1'b1;
          fwd1_data = r_mem_data[w_fwd_idx];
        end
        if ((rs2 != 5'd0) && (r_mem_rd[w_fwd_idx] == rs2)) begin
          fwd2_hit  = 1'b1;
          fwd2_data = r_mem_data[w_fwd_idx];
        end
      end
    end
  end
`else
  // bypass not built: sources are read only by the forwarding network
  logic w_unused_rs;
  assign w_unused_rs = ^{rs1, rs2};
  assign fwd1_hit  = 1'b0;
  assign fwd2_hit  = 1'b0;
  assign fwd1_data = 64'd0;
  assign fwd2_data = 64'd0;
`endif

endmodule
